// File: rtl/life_ctrl_pkg.sv
// Shared types for the life/damage controller.
package life_ctrl_pkg;

  localparam int LIFE_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    HIT       = 3'd2,
    COOLDOWN  = 3'd3,
    GAME_OVER = 3'd4
  } life_state_e;

endpackage

// File: rtl/life_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W-1:0] k;

  // scan far-to-near from ptr so the nearest requester is the last writer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    k       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = PTR_W'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/life_ctrl.sv
// Damage scheduler: round-robin hit grant, 1-cycle life decrement pulse,
// invulnerability cooldown, sticky game over.
// Optional: define LIFE_CTRL_QUEUE_EN to queue hits arriving during cooldown.
module life_ctrl
  import life_ctrl_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int QUEUE_DEPTH   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [N_SRC-1:0]  i_hit_req,
  input  logic [LIFE_W-1:0] i_life_count,
  output logic [N_SRC-1:0]  o_hit_ack,
  output logic              o_minus_life,
  output logic              o_invuln,
  output logic              o_game_over,
  output logic [2:0]        o_state
);

  localparam int PTR_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(INVULN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_CYCLES - 1);

  if (N_SRC < 2 || INVULN_CYCLES < 1 || QUEUE_DEPTH < 1) begin : g_bad_cfg
    $error("life_ctrl: N_SRC>=2, INVULN_CYCLES>=1, QUEUE_DEPTH>=1 required");
  end

  life_state_e      state_q, state_d;
  logic [PTR_W-1:0] rr_ptr;    // next search start (one past the last grant)
  logic [PTR_W-1:0] gnt_q, arb_idx;
  logic             gvld_q, arb_vld, gnt_ld;
  logic [CNT_W-1:0] cnt_q;

`ifdef LIFE_CTRL_QUEUE_EN
  localparam int PEND_W = $clog2(QUEUE_DEPTH + 1);
  logic [PEND_W-1:0] pend_q, pend_inc;
  logic              any_q, q_take;
`endif

  rr_arbiter #(.N(N_SRC), .PTR_W(PTR_W)) u_arb (
    .req     (i_hit_req),
    .ptr     (rr_ptr),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

`ifdef LIFE_CTRL_QUEUE_EN
  // pending count including a request edge seen this cycle
  always_comb begin
    pend_inc = pend_q;
    if (|i_hit_req && !any_q && pend_q != PEND_W'(QUEUE_DEPTH))
      pend_inc = pend_q + 1'b1;
  end
`endif

  // next-state decode
  always_comb begin
    state_d = state_q;
    gnt_ld  = 1'b0;
`ifdef LIFE_CTRL_QUEUE_EN
    q_take  = 1'b0;
`endif
    case (state_q)
      IDLE:      if (i_start) state_d = ARMED;
      ARMED: begin
        if (i_life_count == '0) state_d = GAME_OVER;
        else if (|i_hit_req) begin
          state_d = HIT;
          gnt_ld  = 1'b1;
        end
      end
      HIT:       state_d = COOLDOWN;
      COOLDOWN: begin
        if (cnt_q == '0) begin
          if (i_life_count == '0) state_d = GAME_OVER;
`ifdef LIFE_CTRL_QUEUE_EN
          else if (pend_inc != '0) begin
            state_d = HIT;
            gnt_ld  = 1'b1;
            q_take  = 1'b1;
          end
`endif
          else state_d = ARMED;
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = IDLE;
    endcase
  end

  // state, latched grant and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      gvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_ld) begin
        gnt_q  <= arb_idx;
        gvld_q <= arb_vld;
      end
      if (state_q == HIT && gvld_q)
        rr_ptr <= (gnt_q == PTR_W'(N_SRC - 1)) ? '0 : gnt_q + 1'b1;
    end
  end

  // cooldown counter: loaded in HIT, counts down to 0 in COOLDOWN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (state_q == HIT)                    cnt_q <= CNT_LOAD;
    else if (state_q == COOLDOWN && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

`ifdef LIFE_CTRL_QUEUE_EN
  // pending hits accumulated during cooldown, cleared once the game ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      any_q  <= 1'b0;
    end else begin
      any_q <= |i_hit_req;
      if (state_q == GAME_OVER)     pend_q <= '0;
      else if (state_q == COOLDOWN) pend_q <= q_take ? pend_inc - 1'b1 : pend_inc;
    end
  end
`endif

  // outputs decode straight from state so reset/abort drops them at once
  always_comb begin
    o_hit_ack = '0;
    if (state_q == HIT && gvld_q) o_hit_ack[gnt_q] = 1'b1;
    o_minus_life = (state_q == HIT);
    o_invuln     = (state_q == COOLDOWN);
    o_game_over  = (state_q == GAME_OVER);
    o_state      = state_q;
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Randomized self-checking bench for life_ctrl with a behavioural model.
module tb_life_ctrl;

  localparam int N   = 4;
  localparam int INV = 4;
  localparam int QD  = 3;

  logic       clk, rst_n, start;
  logic [3:0] req, o_hit_ack;
  logic [2:0] life, o_state;
  logic       o_minus_life, o_invuln, o_game_over;

  int total = 0, bad = 0, cyc = 0, dut_pulses = 0;
  logic [3:0] ack_log[$];
  int         pulse_cyc[$];
  bit         auto_life;

  // behavioural model
  bit m_started, m_dead, m_pulse, m_gv, m_prev;
  int m_cool, m_ptr, m_gnt, m_pend;

  life_ctrl #(.N_SRC(N), .INVULN_CYCLES(INV), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_hit_req(req),
    .i_life_count(life), .o_hit_ack(o_hit_ack), .o_minus_life(o_minus_life),
    .o_invuln(o_invuln), .o_game_over(o_game_over), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic mreset();
    m_started = 0; m_dead = 0; m_pulse = 0; m_gv = 0; m_prev = 0;
    m_cool = 0; m_ptr = 0; m_gnt = 0; m_pend = 0;
  endtask

  task automatic mstep();
    bit any, rise;
    int p;
    any  = |req;
    rise = any && !m_prev;
    p    = 0;
    if (m_dead) begin
    end else if (m_pulse) begin
      m_pulse = 0;
      m_cool  = INV;
      if (m_gv) m_ptr = (m_gnt + 1) % N;
    end else if (m_cool > 0) begin
`ifdef LIFE_CTRL_QUEUE_EN
      if (rise && m_pend < QD) m_pend++;
`endif
      m_cool--;
      if (m_cool == 0) begin
        if (life == 0) begin
          m_dead = 1;
          m_pend = 0;
        end
`ifdef LIFE_CTRL_QUEUE_EN
        else if (m_pend > 0) begin
          m_pend--;
          p       = rr_pick(req, m_ptr);
          m_pulse = 1;
          m_gv    = (p >= 0);
          m_gnt   = (p >= 0) ? p : 0;
        end
`endif
      end
    end else if (m_started) begin
      if (life == 0) m_dead = 1;
      else if (any) begin
        m_pulse = 1;
        m_gv    = 1;
        m_gnt   = rr_pick(req, m_ptr);
      end
    end else if (start) m_started = 1;
    m_prev = any;
    if (rise) p = p;
  endtask

  // compare process: step model on the edge, check DUT 1 ns later
  always begin
    logic [3:0] e_ack;
    logic [2:0] e_st;
    @(posedge clk);
    cyc++;
    if (!rst_n) mreset(); else mstep();
    #1;
    e_ack = '0;
    if (m_pulse && m_gv) e_ack = 4'(1 << m_gnt);
    e_st = m_dead ? 3'd4 : m_pulse ? 3'd2 : (m_cool > 0) ? 3'd3 : m_started ? 3'd1 : 3'd0;
    chk("minus_life", o_minus_life, m_pulse);
    chk("hit_ack", o_hit_ack, e_ack);
    chk("invuln", o_invuln, (m_cool > 0) && !m_pulse);
    chk("game_over", o_game_over, m_dead);
    chk("state", o_state, e_st);
    if (o_hit_ack != 4'h0) ack_log.push_back(o_hit_ack);
    if (o_minus_life) begin
      dut_pulses++;
      pulse_cyc.push_back(cyc);
    end
  end

  // a life counter fed by the decrement pulse
  task automatic tick();
    @(negedge clk);
    if (auto_life && m_pulse && life > 0) life = life - 3'd1;
  endtask

  task automatic do_reset();
    rst_n = 0; start = 0; req = 0; auto_life = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    int n0, a0, i0, dens;
    rst_n = 0; start = 0; req = 0; life = 3; auto_life = 0;
    tick(); tick();
    // reset state
    chk("rst_state", o_state, 0);
    chk("rst_outs", {o_hit_ack, o_minus_life, o_invuln, o_game_over}, 0);
    rst_n = 1;

    // 1: hits ignored in IDLE
    req = 4'hF;
    repeat (6) tick();
    chk("idle_state", o_state, 0);
    chk("idle_pulses", dut_pulses, 0);

    // 2: single hit, 1-cycle latency, 4-cycle invuln
    req = 0; start = 1; tick();
    start = 0; req = 4'b0100; life = 3; tick();
    req = 0;
    chk("t2_minus", o_minus_life, 1);
    chk("t2_ack", o_hit_ack, 4'b0100);
    for (int k = 0; k < INV; k++) begin
      tick();
      chk("t2_invuln_on", o_invuln, 1);
    end
    tick();
    chk("t2_invuln_off", o_invuln, 0);

    // 3: held requests rotate 0001,0010,0100 with fixed spacing
    do_reset();
    life = 7; start = 1; tick();
    start = 0; req = 4'hF;
    n0 = dut_pulses; a0 = ack_log.size(); i0 = pulse_cyc.size();
    for (int k = 0; k < 60 && dut_pulses - n0 < 3; k++) tick();
    req = 0;
    chk("t3_pulses", dut_pulses - n0, 3);
    if (ack_log.size() >= a0 + 3 && pulse_cyc.size() >= i0 + 3) begin
      chk("t3_ack0", ack_log[a0], 4'b0001);
      chk("t3_ack1", ack_log[a0+1], 4'b0010);
      chk("t3_ack2", ack_log[a0+2], 4'b0100);
      chk("t3_gap", pulse_cyc[i0+1] - pulse_cyc[i0], INV + 2);
    end

    // 4: last life lost -> game over, no further pulses
    do_reset();
    life = 1; auto_life = 1; start = 1; tick();
    start = 0; req = 4'b0001; tick();
    req = 0;
    n0 = dut_pulses - 1;
    for (int k = 0; k < 20 && !o_game_over; k++) tick();
    chk("t4_game_over", o_game_over, 1);
    req = 4'hF;
    repeat (10) tick();
    req = 0;
    chk("t4_pulses", dut_pulses - n0, 1);
    chk("t4_state", o_state, 4);

    // 5: start at zero lives
    do_reset();
    life = 0; n0 = dut_pulses; start = 1; tick();
    start = 0;
    chk("t5_armed", o_state, 1);
    tick();
    chk("t5_over", o_state, 4);
    chk("t5_pulses", dut_pulses - n0, 0);

    // 6: two request edges during cooldown
    do_reset();
    life = 7; start = 1; tick();
    start = 0; req = 4'b0001; tick();
    n0 = dut_pulses - 1;
    req = 0; tick();
    req = 4'b0001; tick();
    req = 0; tick();
    req = 4'b0001; tick();
    req = 0;
    repeat (25) tick();
`ifdef LIFE_CTRL_QUEUE_EN
    chk("t6_pulses", dut_pulses - n0, 3);
`else
    chk("t6_pulses", dut_pulses - n0, 1);
`endif

    // randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      auto_life = 1'($urandom_range(0, 1));
      life = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) life = 0;
      dens = $urandom_range(1, 6);
      for (int c = 0; c < 70; c++) begin
        start = ($urandom_range(0, 9) == 0);
        req = ($urandom_range(0, dens - 1) == 0) ? 4'($urandom) : 4'h0;
        if (!auto_life && $urandom_range(0, 15) == 0) life = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 149) == 0) begin
          rst_n = 0;
          #1;
          chk("async_rst_minus", o_minus_life, 0);
          chk("async_rst_state", o_state, 0);
          tick();
          rst_n = 1;
        end
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
